// File: rtl/adc_scan_scheduler_if.sv
// rtl/adc_scan_scheduler_if.sv - conversion request and UART byte handshake bundle
interface adc_scan_scheduler_if;
    logic       conv_start;
    logic [2:0] conv_ch;
    logic       conv_done;
    logic [9:0] conv_data;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;

    modport master (
        output conv_start, conv_ch, tx_start, tx_data,
        input  conv_done, conv_data, tx_busy
    );

    modport slave (
        input  conv_start, conv_ch, tx_start, tx_data,
        output conv_done, conv_data, tx_busy
    );
endinterface

// File: rtl/adc_scan_scheduler.sv
// rtl/adc_scan_scheduler.sv - timed ADC channel scan serialized into UART byte pairs
// Optional sync byte 0xA5 before each scan: define ADC_SCAN_SYNC_BYTE_EN.
module adc_scan_scheduler #(
    parameter int NUM_CH     = 8,
    parameter int SAMPLE_DIV = 250000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic [7:0]                  ch_mask,
    adc_scan_scheduler_if.master        bus,
    output logic                        scan_active,
    output logic                        overrun
);
    localparam int TW = $clog2(SAMPLE_DIV);
    localparam logic [TW-1:0] RELOAD = TW'(SAMPLE_DIV - 1);
    localparam logic [7:0] CH_VALID = 8'((16'd1 << NUM_CH) - 16'd1);

    typedef enum logic [3:0] {
        S_IDLE, S_SYNC, S_SYNC_HOLD, S_CONV, S_WAIT_CONV,
        S_SEND_LO, S_HOLD_LO, S_SEND_HI, S_HOLD_HI, S_NEXT
    } state_t;

    state_t          state_q, state_n;
    logic [TW-1:0]   timer_q;
    logic            tick_q;
    logic [7:0]      mask_q, mask_n;
    logic [1:0]      data_hi_q, data_hi_n;
    logic            hold_first_q, hold_first_n;
    logic            conv_start_q, conv_start_n;
    logic [2:0]      conv_ch_q, conv_ch_n;
    logic            tx_start_q, tx_start_n;
    logic [7:0]      tx_data_q, tx_data_n;
    logic            scan_active_q, scan_active_n;
    logic            overrun_q, overrun_n;
    logic [7:0]      masked;
    logic [3:0]      first_sel, next_sel;

    // Lowest set bit at or above 'from'; bit 3 of the result flags a hit.
    function automatic logic [3:0] pick_ch(input logic [7:0] m, input logic [3:0] from);
        logic [3:0] sel;
        sel = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i] && (i >= int'(from))) sel = {1'b1, 3'(i)};
        end
        return sel;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= RELOAD;
            tick_q  <= 1'b0;
        end else begin
            tick_q  <= (timer_q == '0);
            timer_q <= (timer_q == '0) ? RELOAD : timer_q - TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            mask_q        <= '0;
            data_hi_q     <= '0;
            hold_first_q  <= 1'b0;
            conv_start_q  <= 1'b0;
            conv_ch_q     <= '0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= '0;
            scan_active_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_n;
            mask_q        <= mask_n;
            data_hi_q     <= data_hi_n;
            hold_first_q  <= hold_first_n;
            conv_start_q  <= conv_start_n;
            conv_ch_q     <= conv_ch_n;
            tx_start_q    <= tx_start_n;
            tx_data_q     <= tx_data_n;
            scan_active_q <= scan_active_n;
            overrun_q     <= overrun_n;
        end
    end

    always_comb begin
        state_n       = state_q;
        mask_n        = mask_q;
        data_hi_n     = data_hi_q;
        hold_first_n  = 1'b0;
        conv_start_n  = 1'b0;
        conv_ch_n     = conv_ch_q;
        tx_start_n    = 1'b0;
        tx_data_n     = tx_data_q;
        scan_active_n = scan_active_q;
        overrun_n     = overrun_q | (tick_q & scan_active_q);
        masked        = ch_mask & CH_VALID;
        first_sel     = pick_ch(masked, 4'd0);
        next_sel      = pick_ch(mask_q, {1'b0, conv_ch_q} + 4'd1);

        case (state_q)
            S_IDLE: begin
                if (tick_q && !scan_active_q && enable && first_sel[3]) begin
                    mask_n        = masked;
                    scan_active_n = 1'b1;
                    conv_ch_n     = first_sel[2:0];
`ifdef ADC_SCAN_SYNC_BYTE_EN
                    state_n       = S_SYNC;
                    tx_start_n    = !bus.tx_busy;
                    tx_data_n     = 8'hA5;
`else
                    state_n       = S_CONV;
                    conv_start_n  = 1'b1;
`endif
                end
            end
            S_SYNC: begin
                if (tx_start_q) begin
                    state_n      = S_SYNC_HOLD;
                    hold_first_n = 1'b1;
                end else if (!bus.tx_busy) begin
                    tx_start_n = 1'b1;
                end
            end
            S_SYNC_HOLD: begin
                if (!hold_first_q && !bus.tx_busy) begin
                    state_n      = S_CONV;
                    conv_start_n = 1'b1;
                end
            end
            S_CONV: state_n = S_WAIT_CONV;
            S_WAIT_CONV: begin
                if (bus.conv_done) begin
                    data_hi_n  = bus.conv_data[9:8];
                    tx_data_n  = bus.conv_data[7:0];
                    tx_start_n = !bus.tx_busy;
                    state_n    = S_SEND_LO;
                end
            end
            // A SEND state leaves once its start pulse has actually been issued.
            S_SEND_LO: begin
                if (tx_start_q) begin
                    state_n      = S_HOLD_LO;
                    hold_first_n = 1'b1;
                end else if (!bus.tx_busy) begin
                    tx_start_n = 1'b1;
                end
            end
            S_HOLD_LO: begin
                if (!hold_first_q && !bus.tx_busy) begin
                    state_n    = S_SEND_HI;
                    tx_start_n = 1'b1;
                    tx_data_n  = {conv_ch_q, 3'b000, data_hi_q};
                end
            end
            S_SEND_HI: begin
                if (tx_start_q) begin
                    state_n      = S_HOLD_HI;
                    hold_first_n = 1'b1;
                end else if (!bus.tx_busy) begin
                    tx_start_n = 1'b1;
                end
            end
            S_HOLD_HI: begin
                if (!hold_first_q && !bus.tx_busy) state_n = S_NEXT;
            end
            S_NEXT: begin
                if (next_sel[3]) begin
                    conv_ch_n    = next_sel[2:0];
                    conv_start_n = 1'b1;
                    state_n      = S_CONV;
                end else begin
                    scan_active_n = 1'b0;
                    state_n       = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign bus.conv_start = conv_start_q;
    assign bus.conv_ch    = conv_ch_q;
    assign bus.tx_start   = tx_start_q;
    assign bus.tx_data    = tx_data_q;
    assign scan_active    = scan_active_q;
    assign overrun        = overrun_q;
endmodule
